except_ctrl: RTL and testbench



---
 rtl/except_ctrl_pkg.sv | 39 +++
 rtl/except_ctrl_prio.sv | 71 +++++++
 rtl/except_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_except_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/except_ctrl_pkg.sv
// except_ctrl_pkg
// Shared definitions for the MEM/WB exception collector:
//   - CP0 exception codes driven on excepttype_o
//   - controller state encoding
//   - BadVAddr source selector produced by the priority encoder
//   - helper that evaluates whether a hardware interrupt is pending
package except_ctrl_pkg;

  localparam logic [31:0] EXC_INT       = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL      = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES      = 32'h0000_0005;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK     = 32'h0000_0009;
  localparam logic [31:0] EXC_RI        = 32'h0000_000a;
  localparam logic [31:0] EXC_OV        = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT,
    ST_FLUSH
  } state_e;

  typedef enum logic [1:0] {
    BAD_NONE,
    BAD_PC,
    BAD_DATA
  } bad_sel_e;

  // Interrupts are taken only when globally enabled (IE), not already in
  // exception level (EXL), and at least one unmasked line is asserted.
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
  endfunction

endpackage

// File: rtl/except_ctrl_prio.sv
// except_prio
// Purely combinational priority encoder for the MEM-stage exception sources.
// Ports:
//   valid_i              - instruction is real; everything is ignored otherwise
//   cp0_status_i/cause_i - used to derive a pending interrupt
//   *_i flags            - per-instruction exception flags
//   hit_o                - some exception applies to this instruction
//   code_o               - CP0 exception code of the winner
//   bad_sel_o            - which address (if any) becomes BadVAddr
module except_prio
  import except_ctrl_pkg::*;
(
  input  logic        valid_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic        adel_pc_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        trap_i,
  input  logic        ov_i,
  input  logic        eret_i,
  input  logic        adel_data_i,
  input  logic        ades_data_i,
  output logic        hit_o,
  output logic [31:0] code_o,
  output bad_sel_e    bad_sel_o
);

  logic int_pend;
  logic unused_cp0_bits;

  assign int_pend = int_pending(cp0_status_i, cp0_cause_i);
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:16], cp0_cause_i[7:0]};

  always_comb begin
    hit_o     = 1'b1;
    code_o    = 32'h0;
    bad_sel_o = BAD_NONE;
    if (!valid_i) begin
      hit_o = 1'b0;
    end else if (int_pend) begin
      code_o = EXC_INT;
    end else if (adel_pc_i) begin
      code_o    = EXC_ADEL;
      bad_sel_o = BAD_PC;
    end else if (ri_i) begin
      code_o = EXC_RI;
    end else if (syscall_i) begin
      code_o = EXC_SYSCALL;
    end else if (break_i) begin
      code_o = EXC_BREAK;
    end else if (trap_i) begin
      code_o = EXC_TRAP;
    end else if (ov_i) begin
      code_o = EXC_OV;
    end else if (adel_data_i) begin
      code_o    = EXC_ADEL;
      bad_sel_o = BAD_DATA;
    end else if (ades_data_i) begin
      code_o    = EXC_ADES;
      bad_sel_o = BAD_DATA;
    end else if (eret_i) begin
      code_o = EXC_ERET;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl
// Exception collector and commit controller at the MEM/WB boundary.
// Picks the winning exception, waits out memory stalls, then issues a
// single-cycle commit to CP0 together with a pipeline flush and redirect PC.
// Ports:
//   clk, rst (async, active-low)
//   valid_i, pc_i, is_in_delayslot_i, data_vaddr_i, mem_stall_i
//   exception flags adel_pc_i .. ades_data_i, cp0_status/cause/epc_i
//   excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o -> CP0
//   flush_o, new_pc_o -> pipeline redirect; busy_o while not idle
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        adel_pc_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        trap_i,
  input  logic        ov_i,
  input  logic        eret_i,
  input  logic        adel_data_i,
  input  logic        ades_data_i,
  input  logic [31:0] data_vaddr_i,
  input  logic        mem_stall_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  logic        prio_hit;
  logic [31:0] prio_code;
  bad_sel_e    prio_bad_sel;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        ds_q, ds_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] exc_q, exc_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        commit;

  except_prio u_prio (
    .valid_i      (valid_i),
    .cp0_status_i (cp0_status_i),
    .cp0_cause_i  (cp0_cause_i),
    .adel_pc_i    (adel_pc_i),
    .ri_i         (ri_i),
    .syscall_i    (syscall_i),
    .break_i      (break_i),
    .trap_i       (trap_i),
    .ov_i         (ov_i),
    .eret_i       (eret_i),
    .adel_data_i  (adel_data_i),
    .ades_data_i  (ades_data_i),
    .hit_o        (prio_hit),
    .code_o       (prio_code),
    .bad_sel_o    (prio_bad_sel)
  );

  // The exception record is captured only when leaving IDLE, so anything
  // arriving during WAIT/FLUSH can never overwrite it. excepttype/flush/new_pc
  // are forced to zero except on the edge that enters COMMIT, because CP0
  // re-applies any nonzero code it sees.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    pc_d     = pc_q;
    ds_d     = ds_q;
    bad_d    = bad_q;
    exc_d    = 32'h0;
    flush_d  = 1'b0;
    new_pc_d = 32'h0;
    commit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (prio_hit) begin
          code_d = prio_code;
          pc_d   = pc_i;
          ds_d   = is_in_delayslot_i;
          if (prio_bad_sel == BAD_PC) begin
            bad_d = pc_i;
          end else if (prio_bad_sel == BAD_DATA) begin
            bad_d = data_vaddr_i;
          end
          if (mem_stall_i) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_COMMIT;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!mem_stall_i) begin
          state_d = ST_COMMIT;
          commit  = 1'b1;
        end
      end
      ST_COMMIT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    if (commit) begin
      exc_d    = code_d;
      flush_d  = 1'b1;
      new_pc_d = (code_d == EXC_ERET) ? cp0_epc_i : HANDLER_ADDR;
    end
  end

  // State, latched record and registered outputs; reset drops any pending
  // exception immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      code_q   <= 32'h0;
      pc_q     <= 32'h0;
      ds_q     <= 1'b0;
      bad_q    <= 32'h0;
      exc_q    <= 32'h0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      ds_q     <= ds_d;
      bad_q    <= bad_d;
      exc_q    <= exc_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign excepttype_o        = exc_q;
  assign current_inst_addr_o = pc_q;
  assign is_in_delayslot_o   = ds_q;
  assign bad_addr_o          = bad_q;
  assign flush_o             = flush_q;
  assign new_pc_o            = new_pc_q;
  assign busy_o              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl
// Self-checking bench for except_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_except_ctrl;

  localparam logic [31:0] HANDLER = 32'hBFC0_0380;
  localparam int          FLUSH_N = 2;

  localparam logic [8:0] F_NONE      = 9'b000000000;
  localparam logic [8:0] F_ADEL_PC   = 9'b100000000;
  localparam logic [8:0] F_RI        = 9'b010000000;
  localparam logic [8:0] F_OV        = 9'b000001000;
  localparam logic [8:0] F_ERET      = 9'b000000100;
  localparam logic [8:0] F_ADEL_DATA = 9'b000000010;
  localparam logic [8:0] F_ADES_DATA = 9'b000000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        is_in_delayslot_i = 1'b0;
  logic [8:0]  flags = 9'h0;
  logic [31:0] data_vaddr_i = 32'h0;
  logic        mem_stall_i = 1'b0;
  logic [31:0] cp0_status_i = 32'h0;
  logic [31:0] cp0_cause_i = 32'h0;
  logic [31:0] cp0_epc_i = 32'h0;

  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  except_ctrl #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_i             (valid_i),
    .pc_i                (pc_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .adel_pc_i           (flags[8]),
    .ri_i                (flags[7]),
    .syscall_i           (flags[6]),
    .break_i             (flags[5]),
    .trap_i              (flags[4]),
    .ov_i                (flags[3]),
    .eret_i              (flags[2]),
    .adel_data_i         (flags[1]),
    .ades_data_i         (flags[0]),
    .data_vaddr_i        (data_vaddr_i),
    .mem_stall_i         (mem_stall_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .bad_addr_o          (bad_addr_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the pending exception record, whether it is
  // still waiting on memory, and how many busy cycles remain after commit.
  logic [31:0] m_exc = 0, m_pc = 0, m_bad = 0, m_newpc = 0, pend_code = 0;
  logic        m_flush = 0, m_ds = 0, m_busy = 0;
  bit          waiting = 0;
  bit          commit_now;
  int          busy_left = 0;
  int          old_left;
  logic [33:0] dec;

  // Returns {bad_kind[1:0], code[31:0]}; code 0 means nothing to take.
  // bad_kind: 1 = instruction PC, 2 = data address.
  function automatic logic [33:0] ref_decode(input logic v, input logic [8:0] f,
                                             input logic [31:0] st, input logic [31:0] ca);
    logic [31:0] codes [9];
    logic [1:0]  kinds [9];
    codes = '{32'h04, 32'h0a, 32'h08, 32'h09, 32'h0d, 32'h0c, 32'h0e, 32'h04, 32'h05};
    kinds = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    if (!v) return 34'h0;
    if (st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h0)) return {2'd0, 32'h01};
    // eret is lowest priority even though it sits between ov and adel_data
    // in the flag vector, so it is handled after the loop.
    for (int i = 0; i < 9; i++) begin
      if (i != 6 && f[8 - i]) return {kinds[i], codes[i]};
    end
    if (f[2]) return {2'd0, 32'h0e};
    return 34'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_exc = 0; m_pc = 0; m_bad = 0; m_newpc = 0; m_flush = 0; m_ds = 0;
      m_busy = 0; waiting = 0; busy_left = 0; pend_code = 0;
    end else begin
      old_left = busy_left;
      commit_now = 0;
      m_exc = 0; m_flush = 0; m_newpc = 0;
      if (old_left > 0) busy_left = old_left - 1;
      if (waiting) begin
        if (!mem_stall_i) begin
          waiting = 0;
          commit_now = 1;
        end
      end else if (old_left == 0) begin
        dec = ref_decode(valid_i, flags, cp0_status_i, cp0_cause_i);
        if (dec[31:0] != 0) begin
          pend_code = dec[31:0];
          m_pc = pc_i;
          m_ds = is_in_delayslot_i;
          if (dec[33:32] == 2'd1) m_bad = pc_i;
          if (dec[33:32] == 2'd2) m_bad = data_vaddr_i;
          if (mem_stall_i) waiting = 1;
          else commit_now = 1;
        end
      end
      if (commit_now) begin
        m_exc = pend_code;
        m_flush = 1;
        m_newpc = (pend_code == 32'h0e) ? cp0_epc_i : HANDLER;
        busy_left = FLUSH_N;
      end
      m_busy = waiting || (busy_left > 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic compareAll();
    checkOutput("excepttype", excepttype_o, m_exc);
    checkOutput("inst_addr", current_inst_addr_o, m_pc);
    checkOutput("delayslot", {31'b0, is_in_delayslot_o}, {31'b0, m_ds});
    checkOutput("bad_addr", bad_addr_o, m_bad);
    checkOutput("flush", {31'b0, flush_o}, {31'b0, m_flush});
    checkOutput("new_pc", new_pc_o, m_newpc);
    checkOutput("busy", {31'b0, busy_o}, {31'b0, m_busy});
  endtask

  task automatic tick();
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ds,
                               input logic [8:0] f, input logic [31:0] vaddr,
                               input logic stall);
    valid_i = v;
    pc_i = pc;
    is_in_delayslot_i = ds;
    flags = f;
    data_vaddr_i = vaddr;
    mem_stall_i = stall;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drops reset mid-cycle and checks the asynchronous clear before any edge.
  task automatic pulseReset();
    #2 rst = 1'b0;
    #1;
    compareAll();
    checkOutput("rst_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("rst_exc", excepttype_o, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #12;
    checkOutput("reset_exc", excepttype_o, 32'h0);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    checkOutput("idle_exc", excepttype_o, 32'h0);

    // overflow, no stall
    applyStimulus(1'b1, 32'hBFC0_1000, 1'b0, F_OV, 32'h0, 1'b0);
    tick();
    checkOutput("ov_code", excepttype_o, 32'h0c);
    checkOutput("ov_pc", current_inst_addr_o, 32'hBFC0_1000);
    checkOutput("ov_flush", {31'b0, flush_o}, 32'h1);
    checkOutput("ov_newpc", new_pc_o, 32'hBFC0_0380);
    checkOutput("ov_busy1", {31'b0, busy_o}, 32'h1);
    idle(1);
    checkOutput("ov_after", excepttype_o, 32'h0);
    checkOutput("ov_busy2", {31'b0, busy_o}, 32'h1);
    idle(1);
    checkOutput("ov_busy_end", {31'b0, busy_o}, 32'h0);

    // interrupt beats overflow; masked by EXL
    cp0_status_i = 32'h0000_0401;
    cp0_cause_i  = 32'h0000_0400;
    applyStimulus(1'b1, 32'hBFC0_1100, 1'b0, F_OV, 32'h0, 1'b0);
    tick();
    checkOutput("int_code", excepttype_o, 32'h01);
    idle(3);
    cp0_status_i = 32'h0000_0403;
    applyStimulus(1'b1, 32'hBFC0_1104, 1'b0, F_OV, 32'h0, 1'b0);
    tick();
    checkOutput("exl_code", excepttype_o, 32'h0c);
    idle(3);
    cp0_status_i = 32'h0;
    cp0_cause_i  = 32'h0;

    // store address error held in WAIT for three stall cycles
    applyStimulus(1'b1, 32'hBFC0_1200, 1'b0, F_ADES_DATA, 32'h8000_0003, 1'b1);
    tick();
    checkOutput("ades_wait1", excepttype_o, 32'h0);
    applyStimulus(1'b1, 32'hBFC0_1300, 1'b0, F_RI, 32'h0, 1'b1);
    tick();
    checkOutput("ades_wait2", {31'b0, busy_o}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 1'b1);
    tick();
    checkOutput("ades_wait3", excepttype_o, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 1'b0);
    tick();
    checkOutput("ades_code", excepttype_o, 32'h05);
    checkOutput("ades_bad", bad_addr_o, 32'h8000_0003);
    checkOutput("ades_pc", current_inst_addr_o, 32'hBFC0_1200);
    idle(3);

    // eret redirects to EPC
    cp0_epc_i = 32'hBFC0_2004;
    applyStimulus(1'b1, 32'hBFC0_1400, 1'b0, F_ERET, 32'h0, 1'b0);
    tick();
    checkOutput("eret_code", excepttype_o, 32'h0e);
    checkOutput("eret_newpc", new_pc_o, 32'hBFC0_2004);
    checkOutput("eret_bad_hold", bad_addr_o, 32'h8000_0003);
    idle(3);

    // bubble ignored, then real delay-slot RI
    applyStimulus(1'b0, 32'hBFC0_1500, 1'b1, F_RI, 32'h0, 1'b0);
    tick();
    checkOutput("bubble_exc", excepttype_o, 32'h0);
    checkOutput("bubble_busy", {31'b0, busy_o}, 32'h0);
    applyStimulus(1'b1, 32'hBFC0_1500, 1'b1, F_RI, 32'h0, 1'b0);
    tick();
    checkOutput("ri_code", excepttype_o, 32'h0a);
    checkOutput("ri_ds", {31'b0, is_in_delayslot_o}, 32'h1);
    idle(3);

    // adel on fetch PC
    applyStimulus(1'b1, 32'hBFC0_1601, 1'b0, F_ADEL_PC | F_RI, 32'h1234, 1'b0);
    tick();
    checkOutput("adelpc_code", excepttype_o, 32'h04);
    checkOutput("adelpc_bad", bad_addr_o, 32'hBFC0_1601);
    idle(3);

    // reset during WAIT drops the exception
    applyStimulus(1'b1, 32'hBFC0_1700, 1'b0, F_ADEL_DATA, 32'h0000_1235, 1'b1);
    tick();
    pulseReset();
    idle(4);

    // reset during FLUSH
    applyStimulus(1'b1, 32'hBFC0_1800, 1'b0, F_OV, 32'h0, 1'b0);
    tick();
    idle(1);
    pulseReset();
    idle(3);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [8:0] f;
      for (int b = 0; b < 9; b++) f[b] = ($urandom_range(0, 11) == 0);
      cp0_status_i = {$urandom_range(0, 65535), 16'h0} |
                     {16'h0, 8'($urandom_range(0, 255)), 6'h0, 2'($urandom_range(0, 3))};
      cp0_cause_i  = ($urandom_range(0, 3) == 0) ? {16'h0, 8'($urandom_range(0, 255)), 8'h0} : 32'h0;
      cp0_epc_i    = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, {$urandom} & 32'hFFFF_FFFC,
                    1'($urandom_range(0, 1)), f, $urandom, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) pulseReset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
